// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared DES key-schedule tables, constants and helpers
// Purpose: PC-1/PC-2 tables (1-based DES bit numbers, bit 1 = MSB),
//          the encrypt shift schedule, widths, state type and rotation helpers.
// Ports:   none (package)
package des_pkg;

    localparam int DES_KEY_W    = 64;
    localparam int DES_CD_W     = 56;
    localparam int DES_SUBKEY_W = 48;
    localparam int DES_ROUNDS   = 16;

    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_SCHED [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Rotation applied to reach issue idx. Decrypt walks the encrypt
    // schedule backwards: issue 0 is C16/D16 == C0/D0 (no rotation), and
    // issue i undoes encrypt shift 16-i (4-bit wrap of 0-idx gives 16-idx).
    function automatic logic [1:0] rot_amount(input logic dec, input logic [3:0] idx);
        if (!dec) begin
            return SHIFT_SCHED[idx];
        end else if (idx == 4'd0) begin
            return 2'd0;
        end else begin
            return SHIFT_SCHED[4'd0 - idx];
        end
    endfunction

    // Rotate one 28-bit half: left for encrypt, right for decrypt.
    function automatic logic [27:0] rot_half(input logic [27:0] x, input logic dec,
                                             input logic [1:0] n);
        logic [27:0] r;
        r = x;
        case ({dec, n})
            3'b0_01: r = {x[26:0], x[27]};
            3'b0_10: r = {x[25:0], x[27:26]};
            3'b1_01: r = {x[0], x[27:1]};
            3'b1_10: r = {x[1:0], x[27:2]};
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/des_pc2_perm.sv
// rtl/des_pc2_perm.sv - DES PC-2 permutation, 56-bit C/D to 48-bit subkey
// Purpose: pure combinational bit selection.
// Ports:   cd     in  56  C=[55:28], D=[27:0], cd[55] = C bit 1
//          subkey out 48  subkey[47] = PC-2 output bit 1
module des_pc2_perm
    import des_pkg::*;
(
    input  logic [DES_CD_W-1:0]     cd,
    output logic [DES_SUBKEY_W-1:0] subkey
);

    for (genvar i = 0; i < DES_SUBKEY_W; i++) begin : g_pc2
        assign subkey[DES_SUBKEY_W-1-i] = cd[DES_CD_W-PC2_TABLE[i]];
    end

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - iterative DES round-subkey generator
// Purpose: accepts one 64-bit key, applies PC-1, then issues 16 subkeys one
//          per handshake, K1..K16 (encrypt) or K16..K1 (decrypt).
// Ports:   clk, rst (sync, active-high)
//          key_valid/key_ready/key[63:0]/decrypt      key input handshake
//          subkey_valid/subkey_ready/subkey[47:0]     subkey output handshake
//          round[3:0] issue index, subkey_last        high with 16th subkey
module des_key_schedule
    import des_pkg::*;
#(
    parameter bit BACK_TO_BACK = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    output logic                    key_ready,
    input  logic [DES_KEY_W-1:0]    key,
    input  logic                    decrypt,
    output logic                    subkey_valid,
    input  logic                    subkey_ready,
    output logic [DES_SUBKEY_W-1:0] subkey,
    output logic [3:0]              round,
    output logic                    subkey_last
);

    state_t                 state_q, state_d;
    logic [DES_CD_W-1:0]    cd_q, cd_d;
    logic [3:0]             round_q, round_d;
    logic                   dec_q, dec_d;

    logic [DES_CD_W-1:0]     pc1_key;
    logic [DES_CD_W-1:0]     load_cd;
    logic [DES_CD_W-1:0]     adv_cd;
    logic [3:0]              next_round;
    logic [1:0]              load_rot;
    logic [1:0]              adv_rot;
    logic [DES_SUBKEY_W-1:0] pc2_out;
    logic                    last;

    // PC-1: key[63] is DES bit 1, so DES bit n lives at key[64-n].
    for (genvar i = 0; i < DES_CD_W; i++) begin : g_pc1
        assign pc1_key[DES_CD_W-1-i] = key[DES_KEY_W-PC1_TABLE[i]];
    end

    assign load_rot   = rot_amount(decrypt, 4'd0);
    assign load_cd    = {rot_half(pc1_key[55:28], decrypt, load_rot),
                         rot_half(pc1_key[27:0],  decrypt, load_rot)};

    assign next_round = round_q + 4'd1;
    assign adv_rot    = rot_amount(dec_q, next_round);
    assign adv_cd     = {rot_half(cd_q[55:28], dec_q, adv_rot),
                         rot_half(cd_q[27:0],  dec_q, adv_rot)};

    des_pc2_perm u_pc2 (
        .cd     (cd_q),
        .subkey (pc2_out)
    );

    assign last = (state_q == RUN) && (round_q == 4'd15);

    always_comb begin
        state_d      = state_q;
        cd_d         = cd_q;
        round_d      = round_q;
        dec_d        = dec_q;
        key_ready    = 1'b0;
        subkey_valid = 1'b0;
        case (state_q)
            IDLE: begin
                key_ready = !rst;
                if (key_valid && !rst) begin
                    cd_d    = load_cd;
                    round_d = 4'd0;
                    dec_d   = decrypt;
                    state_d = RUN;
                end
            end
            RUN: begin
                subkey_valid = 1'b1;
                // Reloading in the last-handshake cycle removes the bubble
                // between schedules; this makes key_ready depend on subkey_ready.
                if (BACK_TO_BACK && last) begin
                    key_ready = subkey_ready && !rst;
                end
                if (subkey_ready) begin
                    if (!last) begin
                        cd_d    = adv_cd;
                        round_d = next_round;
                    end else if (key_valid && key_ready) begin
                        cd_d    = load_cd;
                        round_d = 4'd0;
                        dec_d   = decrypt;
                    end else begin
                        round_d = 4'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cd_q    <= '0;
            round_q <= 4'd0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            round_q <= round_d;
            dec_q   <= dec_d;
        end
    end

    assign subkey      = subkey_valid ? pc2_out : '0;
    assign round       = round_q;
    assign subkey_last = last;

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - self-checking bench for des_key_schedule
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key;
    logic        decrypt;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        subkey_last;

    logic        key_valid_z;
    logic        key_ready_z;
    logic [63:0] key_z;
    logic        decrypt_z;
    logic        subkey_valid_z;
    logic        subkey_ready_z;
    logic [47:0] subkey_z;
    logic [3:0]  round_z;
    logic        subkey_last_z;

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0] model_ks [16];
    logic [47:0] got      [16];

    always #5 clk = ~clk;

    des_key_schedule #(.BACK_TO_BACK(1'b1)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
        .key(key), .decrypt(decrypt), .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready), .subkey(subkey), .round(round),
        .subkey_last(subkey_last)
    );

    des_key_schedule #(.BACK_TO_BACK(1'b0)) dut_z (
        .clk(clk), .rst(rst), .key_valid(key_valid_z), .key_ready(key_ready_z),
        .key(key_z), .decrypt(decrypt_z), .subkey_valid(subkey_valid_z),
        .subkey_ready(subkey_ready_z), .subkey(subkey_z), .round(round_z),
        .subkey_last(subkey_last_z)
    );

    // Reference: textbook DES schedule (cumulative left shifts from C0/D0,
    // then PC-2); decrypt order is simply the encrypt list reversed.
    int ref_pc1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                         60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                         29,21,13,5,28,20,12,4};
    int ref_pc2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                         41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int ref_shift [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    task automatic build_model(input logic [63:0] k, input bit d);
        logic [55:0] cd0;
        logic [27:0] c, dd;
        logic [55:0] cd;
        logic [47:0] sk;
        logic [47:0] tmp [16];
        for (int i = 0; i < 56; i++) cd0[6'(55 - i)] = k[6'(64 - ref_pc1[i])];
        c  = cd0[55:28];
        dd = cd0[27:0];
        for (int r = 0; r < 16; r++) begin
            c  = (c  << ref_shift[r]) | (c  >> (28 - ref_shift[r]));
            dd = (dd << ref_shift[r]) | (dd >> (28 - ref_shift[r]));
            cd = {c, dd};
            for (int j = 0; j < 48; j++) sk[6'(47 - j)] = cd[6'(56 - ref_pc2[j])];
            tmp[r] = sk;
        end
        for (int r = 0; r < 16; r++) model_ks[r] = d ? tmp[15 - r] : tmp[r];
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load_key(input logic [63:0] k, input bit d);
        int g;
        @(negedge clk);
        key = k;
        decrypt = d;
        key_valid = 1'b1;
        g = 0;
        while (!key_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("key_accept", key_ready, 1'b1);
    endtask

    // Consume issues start..stop-1, checking each presented subkey every cycle
    // (including stalled ones) against the model.
    task automatic collect(input int start, input int stop, input int pct);
        int n, guard;
        bit first;
        n = start;
        guard = 0;
        first = 1'b1;
        while (n < stop && guard < 1000) begin
            @(negedge clk);
            guard++;
            key_valid = 1'b0;
            subkey_ready = ($urandom_range(0, 99) < pct);
            if (first && start == 0) chk("latency_valid", subkey_valid, 1'b1);
            first = 1'b0;
            if (subkey_valid) begin
                chk("subkey", subkey, model_ks[n]);
                chk("round", round, 64'(n));
                chk("subkey_last", subkey_last, 64'(n == 15));
                if (subkey_ready) begin
                    got[n] = subkey;
                    n++;
                end
            end
        end
        chk("handshake_count", 64'(n), 64'(stop));
    endtask

    typedef struct {
        logic [63:0] k;
        bit          d;
        int          pct;
        logic [47:0] first;
        logic [47:0] last;
    } vec_t;

    vec_t vt [4];

    initial begin
        logic [63:0] ka, kb, kc;
        int bubbles, g;
        bit d;

        vt[0] = '{64'h133457799BBCDFF1, 1'b0, 100, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
        vt[1] = '{64'h133457799BBCDFF1, 1'b1, 100, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
        vt[2] = '{64'h123556789ABDDEF0, 1'b0,  50, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
        vt[3] = '{64'h123556789ABDDEF0, 1'b1,  50, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};

        rst = 1'b1;
        key_valid = 1'b0; key = '0; decrypt = 1'b0; subkey_ready = 1'b0;
        key_valid_z = 1'b0; key_z = '0; decrypt_z = 1'b0; subkey_ready_z = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_key_ready", key_ready, 1'b0);
        chk("rst_valid", subkey_valid, 1'b0);
        chk("rst_subkey", subkey, 48'h0);
        chk("rst_round", round, 4'd0);
        chk("rst_last", subkey_last, 1'b0);
        rst = 1'b0;
        #1;
        chk("idle_key_ready", key_ready, 1'b1);

        // Table vectors: known answers, decrypt order, parity independence.
        for (int v = 0; v < 4; v++) begin
            build_model(vt[v].k, vt[v].d);
            load_key(vt[v].k, vt[v].d);
            collect(0, 16, vt[v].pct);
            chk("vec_first", got[0], vt[v].first);
            chk("vec_last", got[15], vt[v].last);
            @(negedge clk);
            subkey_ready = 1'b0;
            chk("post_idle_valid", subkey_valid, 1'b0);
            chk("post_idle_ready", key_ready, 1'b1);
        end

        // Random keys with random direction under ~50% backpressure.
        for (int r = 0; r < 6; r++) begin
            ka = {$urandom, $urandom};
            d = 1'($urandom_range(0, 1));
            build_model(ka, d);
            load_key(ka, d);
            collect(0, 16, 50);
        end

        // Back-to-back reload on the last handshake (BACK_TO_BACK=1).
        ka = {$urandom, $urandom};
        kb = {$urandom, $urandom};
        build_model(ka, 1'b0);
        load_key(ka, 1'b0);
        collect(0, 15, 100);
        @(negedge clk);
        key = kb; decrypt = 1'b0; key_valid = 1'b1; subkey_ready = 1'b0;
        #1;
        chk("b2b_round15", round, 4'd15);
        chk("b2b_last", subkey_last, 1'b1);
        chk("b2b_subkey15", subkey, model_ks[15]);
        chk("b2b_ready_gated", key_ready, 1'b0);
        subkey_ready = 1'b1;
        #1;
        chk("b2b_ready_comb", key_ready, 1'b1);
        build_model(kb, 1'b0);
        @(negedge clk);
        key_valid = 1'b0;
        chk("b2b_no_bubble", subkey_valid, 1'b1);
        chk("b2b_round0", round, 4'd0);
        chk("b2b_k1", subkey, model_ks[0]);
        collect(1, 16, 100);

        // Same sequence with BACK_TO_BACK=0: exactly one idle cycle.
        build_model(ka, 1'b0);
        @(negedge clk);
        key_z = ka; decrypt_z = 1'b0; key_valid_z = 1'b1; subkey_ready_z = 1'b1;
        chk("z_key_ready", key_ready_z, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            key_valid_z = (i == 15);
            key_z = (i == 15) ? kb : ka;
            chk("z_subkey", subkey_z, model_ks[i]);
            chk("z_round", round_z, 64'(i));
            if (i == 15) chk("z_ready_run", key_ready_z, 1'b0);
        end
        build_model(kb, 1'b0);
        bubbles = 0;
        g = 0;
        do begin
            @(negedge clk);
            g++;
            if (!subkey_valid_z) bubbles++;
        end while (!subkey_valid_z && g < 10);
        key_valid_z = 1'b0;
        subkey_ready_z = 1'b0;
        chk("z_bubbles", 64'(bubbles), 64'd1);
        chk("z_round0", round_z, 4'd0);
        chk("z_k1", subkey_z, model_ks[0]);

        // Reset mid-schedule at round 7.
        kc = {$urandom, $urandom};
        build_model(ka, 1'b1);
        load_key(ka, 1'b1);
        collect(0, 7, 100);
        @(negedge clk);
        subkey_ready = 1'b0;
        chk("mid_round7", round, 4'd7);
        rst = 1'b1;
        #1;
        chk("mid_rst_key_ready", key_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_valid", subkey_valid, 1'b0);
        chk("mid_round", round, 4'd0);
        chk("mid_key_ready", key_ready, 1'b1);
        chk("mid_subkey", subkey, 48'h0);
        chk("mid_last", subkey_last, 1'b0);
        build_model(kc, 1'b0);
        load_key(kc, 1'b0);
        collect(0, 16, 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
